// File: rtl/mips_instr_fetch.sv
// Instruction fetch/issue stage ahead of mips_core: loadable IMEM, PC walker,
// R-type legality screen and a credit-controlled issue FIFO.
module mips_instr_fetch #(
  parameter int unsigned IMEM_DEPTH  = 256,
  parameter int unsigned QUEUE_DEPTH = 4,
  parameter logic [31:0] PC_RESET    = 32'h0000_0000
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic                          start_i,
  input  logic                          load_en_i,
  input  logic [$clog2(IMEM_DEPTH)-1:0] load_addr_i,
  input  logic [31:0]                   load_data_i,
  output logic [31:0]                   instruction_set_o,
  output logic                          instr_valid_o,
  input  logic                          instr_ready_i,
  output logic [31:0]                   pc_out_o,
  output logic                          busy_o,
  output logic                          halted_o,
  output logic [7:0]                    illegal_cnt_o
);
  localparam int AW = $clog2(IMEM_DEPTH);
  localparam int QW = $clog2(QUEUE_DEPTH);
  localparam logic [QW:0] QD      = (QW+1)'(QUEUE_DEPTH);
  localparam logic [31:0] SYSCALL = 32'h0000_000C;

  // state  | meaning
  // IDLE   | after reset, waiting for start
  // FETCH  | issuing reads, classifying returned words
  // DRAIN  | SYSCALL seen, waiting for FIFO to empty
  // HALT   | program finished, waiting for start
  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_DRAIN, S_HALT} state_t;

  state_t        state_q, state_d;
  logic [31:0]   pc_q, pc_d;
  logic [7:0]    illegal_q, illegal_d;
  logic          inflight_q;
  logic [31:0]   rdata_q;
  logic [31:0]   mem_q  [IMEM_DEPTH];
  logic [31:0]   fifo_q [QUEUE_DEPTH];
  logic [QW-1:0] wr_ptr_q, rd_ptr_q;
  logic [QW:0]   count_q, count_d;

  logic          issue, push, pop, is_halt, is_legal, can_load;
  logic [QW:0]   credit;
  logic [AW+1:0] pc_lo_inc;

  function automatic logic legal_rtype(input logic [31:0] w);
    logic ok;
    ok = 1'b0;
    case (w[5:0])
      6'h20, 6'h21, 6'h22, 6'h24, 6'h25,
      6'h03, 6'h02, 6'h00, 6'h2B: ok = (w[31:26] == 6'd0);
      default:                    ok = 1'b0;
    endcase
    return ok;
  endfunction

  always_comb begin
    instr_valid_o = (count_q != '0);
    pop           = instr_valid_o && instr_ready_i;
    is_halt       = inflight_q && (rdata_q == SYSCALL);
    is_legal      = legal_rtype(rdata_q);
    push          = inflight_q && !is_halt && is_legal;
    // A pop this cycle frees a slot for the read issued this cycle.
    credit        = count_q + (QW+1)'(inflight_q) - (QW+1)'(pop);
    issue         = (state_q == S_FETCH) && !is_halt && (credit < QD);
    can_load      = (state_q == S_IDLE) || (state_q == S_HALT);
    pc_lo_inc     = pc_q[AW+1:0] + (AW+2)'(4);
    count_d       = count_q + (QW+1)'(push) - (QW+1)'(pop);
  end

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    illegal_d = illegal_q;
    case (state_q)
      S_IDLE, S_HALT: begin
        if (start_i) begin
          state_d   = S_FETCH;
          pc_d      = PC_RESET;
          illegal_d = 8'd0;
        end
      end
      S_FETCH: begin
        if (issue) pc_d = {{(30-AW){1'b0}}, pc_lo_inc};
        if (is_halt) state_d = S_DRAIN;
        if (inflight_q && !is_halt && !is_legal && (illegal_q != 8'hFF))
          illegal_d = illegal_q + 8'd1;
      end
      S_DRAIN: begin
        if (count_q == '0) state_d = S_HALT;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= S_IDLE;
      pc_q       <= PC_RESET;
      illegal_q  <= 8'd0;
      inflight_q <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      illegal_q  <= illegal_d;
      inflight_q <= issue;
      wr_ptr_q   <= wr_ptr_q + QW'(push);
      rd_ptr_q   <= rd_ptr_q + QW'(pop);
      count_q    <= count_d;
    end
  end

  // Storage is deliberately not reset so a program survives rst.
  always_ff @(posedge clk_i) begin
    if (load_en_i && can_load) mem_q[load_addr_i] <= load_data_i;
    if (issue) rdata_q <= mem_q[pc_q[AW+1:2]];
    if (push) fifo_q[wr_ptr_q] <= rdata_q;
  end

  assign instruction_set_o = instr_valid_o ? fifo_q[rd_ptr_q] : 32'd0;
  assign pc_out_o          = pc_q;
  assign busy_o            = (state_q == S_FETCH) || (state_q == S_DRAIN);
  assign halted_o          = (state_q == S_HALT);
  assign illegal_cnt_o     = illegal_q;

endmodule

// File: tb/tb_mips_instr_fetch.sv
// Self-checking bench for mips_instr_fetch: directed scenarios plus random
// programs checked against a program-walk reference model.
module tb_mips_instr_fetch;
  localparam logic [31:0] SYSCALL = 32'h0000_000C;
  localparam logic [31:0] ADD_W   = 32'h0043_5020;
  localparam logic [31:0] SUB_W   = 32'h00A4_5022;
  localparam logic [5:0]  LEGAL_F [9] = '{6'h20, 6'h21, 6'h22, 6'h24, 6'h25, 6'h03, 6'h02, 6'h00, 6'h2B};
  localparam logic [5:0]  BAD_F   [4] = '{6'h18, 6'h1A, 6'h08, 6'h26};

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, start, load_en, ready, valid, busy, halted;
  logic [7:0] load_addr, ill;
  logic [31:0] load_data, instr, pc;
  logic w_start, w_load_en, w_ready, w_valid, w_busy, w_halted;
  logic [7:0] w_load_addr, w_ill;
  logic [31:0] w_load_data, w_instr, w_pc;

  mips_instr_fetch dut (
    .clk_i(clk), .rst_i(rst), .start_i(start), .load_en_i(load_en),
    .load_addr_i(load_addr), .load_data_i(load_data),
    .instruction_set_o(instr), .instr_valid_o(valid), .instr_ready_i(ready),
    .pc_out_o(pc), .busy_o(busy), .halted_o(halted), .illegal_cnt_o(ill));

  mips_instr_fetch #(.PC_RESET(32'h0000_03FC)) dut_w (
    .clk_i(clk), .rst_i(rst), .start_i(w_start), .load_en_i(w_load_en),
    .load_addr_i(w_load_addr), .load_data_i(w_load_data),
    .instruction_set_o(w_instr), .instr_valid_o(w_valid), .instr_ready_i(w_ready),
    .pc_out_o(w_pc), .busy_o(w_busy), .halted_o(w_halted), .illegal_cnt_o(w_ill));

  int checks = 0;
  int failures = 0;
  logic [31:0] mem_m [256];
  logic [31:0] exp_q[$];
  logic [31:0] got_q[$];
  int exp_ill;
  logic [31:0] exp_pc;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [7:0] a, input logic [31:0] d);
    load_en = 1'b1; load_addr = a; load_data = d; mem_m[a] = d;
    tick();
    load_en = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  function automatic logic [31:0] rand_word(input bit legal);
    logic [31:0] w;
    if (legal) w = {6'd0, 20'($urandom), LEGAL_F[$urandom_range(0, 8)]};
    else if ($urandom_range(0, 1) == 1) w = {6'($urandom_range(1, 63)), 26'($urandom)};
    else w = {6'd0, 20'($urandom), BAD_F[$urandom_range(0, 3)]};
    return w;
  endfunction

  // Walk the program as written in memory: what gets issued, what gets dropped,
  // and where the PC rests after the SYSCALL.
  function automatic void model(input logic [31:0] pc0);
    logic [31:0] p, w;
    int n_ill;
    exp_q.delete();
    n_ill = 0;
    p = pc0;
    for (int n = 0; n < 256; n++) begin
      w = mem_m[p[9:2]];
      p = (p + 32'd4) % 32'd1024;
      if (w == SYSCALL) break;
      if (w[31:26] == 6'd0 && (w[5:0] inside {6'h20, 6'h21, 6'h22, 6'h24, 6'h25, 6'h03, 6'h02, 6'h00, 6'h2B}))
        exp_q.push_back(w);
      else if (n_ill < 255)
        n_ill++;
    end
    exp_ill = n_ill;
    exp_pc  = p;
  endfunction

  // Consume from dut until halted, checking the head holds while stalled.
  task automatic run_prog(input int max_cyc, input bit rnd, input bit inject, output bit timed_out);
    logic [31:0] held;
    bit hold_chk;
    hold_chk = 1'b0;
    held = '0;
    timed_out = 1'b1;
    got_q.delete();
    for (int c = 0; c < max_cyc; c++) begin
      if (hold_chk) begin
        checks++;
        if (instr !== held) begin
          failures++;
          $display("FAIL stall_hold got=%h exp=%h", instr, held);
        end
      end
      ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      if (inject && c == 3) begin
        start = 1'b1; load_en = 1'b1; load_addr = 8'd0; load_data = 32'hDEAD_BEEF;
      end
      if (valid && ready) got_q.push_back(instr);
      hold_chk = valid && !ready;
      held = instr;
      tick();
      start = 1'b0; load_en = 1'b0;
      if (halted) begin
        timed_out = 1'b0;
        break;
      end
    end
    ready = 1'b0;
  endtask

  task automatic test_reset();
    checks++; if (valid !== 1'b0) begin failures++; $display("FAIL rst_valid got=%b exp=0", valid); end
    checks++; if (instr !== 32'd0) begin failures++; $display("FAIL rst_instr got=%h exp=0", instr); end
    checks++; if (pc !== 32'd0) begin failures++; $display("FAIL rst_pc got=%h exp=0", pc); end
    checks++; if (busy !== 1'b0 || halted !== 1'b0) begin failures++; $display("FAIL rst_busy_halt got=%b%b exp=00", busy, halted); end
    checks++; if (ill !== 8'd0) begin failures++; $display("FAIL rst_ill got=%0d exp=0", ill); end
    checks++; if (w_pc !== 32'h3FC) begin failures++; $display("FAIL rst_wpc got=%h exp=3fc", w_pc); end
  endtask

  task automatic test_basic();
    bit to;
    load(8'd0, ADD_W); load(8'd1, SUB_W); load(8'd2, SYSCALL);
    ready = 1'b1;
    pulse_start();
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL basic_busy got=%b exp=1", busy); end
    tick();
    checks++; if (valid !== 1'b0) begin failures++; $display("FAIL basic_early_valid got=%b exp=0", valid); end
    tick();
    checks++; if (valid !== 1'b1 || instr !== ADD_W) begin failures++; $display("FAIL basic_first got=%b/%h exp=1/%h", valid, instr, ADD_W); end
    tick();
    checks++; if (valid !== 1'b1 || instr !== SUB_W) begin failures++; $display("FAIL basic_second got=%b/%h exp=1/%h", valid, instr, SUB_W); end
    to = 1'b1;
    for (int c = 0; c < 20; c++) begin
      tick();
      if (halted) begin to = 1'b0; break; end
    end
    ready = 1'b0;
    checks++; if (to) begin failures++; $display("FAIL basic_halt_timeout got=busy exp=halted"); end
    checks++; if (pc !== 32'h0000_000C) begin failures++; $display("FAIL basic_pc got=%h exp=0000000c", pc); end
    checks++; if (ill !== 8'd0 || valid !== 1'b0) begin failures++; $display("FAIL basic_end got=ill%0d/v%b exp=0/0", ill, valid); end
  endtask

  task automatic test_backpressure();
    bit to;
    load(8'd0, ADD_W);
    for (int i = 1; i < 6; i++) load(8'(i), rand_word(1'b1));
    load(8'd6, SYSCALL);
    model(32'd0);
    ready = 1'b0;
    pulse_start();
    for (int c = 0; c < 8; c++) tick();
    checks++; if (pc !== 32'h10) begin failures++; $display("FAIL bp_pc got=%h exp=00000010", pc); end
    checks++; if (valid !== 1'b1 || instr !== ADD_W) begin failures++; $display("FAIL bp_head got=%b/%h exp=1/%h", valid, instr, ADD_W); end
    for (int c = 0; c < 3; c++) tick();
    checks++; if (pc !== 32'h10 || instr !== ADD_W) begin failures++; $display("FAIL bp_frozen got=%h/%h exp=00000010/%h", pc, instr, ADD_W); end
    run_prog(100, 1'b0, 1'b0, to);
    checks++; if (to) begin failures++; $display("FAIL bp_halt_timeout got=busy exp=halted"); end
    checks++; if (got_q.size() != exp_q.size()) begin failures++; $display("FAIL bp_len got=%0d exp=%0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      checks++; if (got_q[i] !== exp_q[i]) begin failures++; $display("FAIL bp_word%0d got=%h exp=%h", i, got_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_illegal();
    bit to;
    load(8'd0, 32'h8C01_0000); load(8'd1, 32'h0043_0018);
    load(8'd2, 32'h0167_502B); load(8'd3, SYSCALL);
    model(32'd0);
    pulse_start();
    run_prog(100, 1'b1, 1'b0, to);
    checks++; if (to) begin failures++; $display("FAIL ill_halt_timeout got=busy exp=halted"); end
    checks++; if (got_q.size() != 1 || got_q[0] !== 32'h0167_502B) begin failures++; $display("FAIL ill_seq got_len=%0d exp=1 word 0167502b", got_q.size()); end
    checks++; if (ill !== 8'd2) begin failures++; $display("FAIL ill_cnt got=%0d exp=2", ill); end
  endtask

  task automatic test_wrap();
    logic [31:0] wq[$];
    bit to;
    for (int i = 0; i < 256; i++) begin
      w_load_en = 1'b1; w_load_addr = 8'(i); w_load_data = (i == 1) ? SYSCALL : ADD_W;
      tick();
    end
    w_load_en = 1'b0;
    w_ready = 1'b1;
    w_start = 1'b1; tick(); w_start = 1'b0;
    checks++; if (w_pc !== 32'h3FC) begin failures++; $display("FAIL wrap_start_pc got=%h exp=000003fc", w_pc); end
    tick();
    checks++; if (w_pc !== 32'h0) begin failures++; $display("FAIL wrap_pc0 got=%h exp=00000000", w_pc); end
    to = 1'b1;
    for (int c = 0; c < 30; c++) begin
      if (w_valid) wq.push_back(w_instr);
      tick();
      if (w_halted) begin to = 1'b0; break; end
    end
    w_ready = 1'b0;
    checks++; if (to) begin failures++; $display("FAIL wrap_halt_timeout got=busy exp=halted"); end
    checks++; if (wq.size() != 2) begin failures++; $display("FAIL wrap_len got=%0d exp=2", wq.size()); end
    for (int i = 0; i < wq.size(); i++) begin
      checks++; if (wq[i] !== ADD_W) begin failures++; $display("FAIL wrap_word%0d got=%h exp=%h", i, wq[i], ADD_W); end
    end
    checks++; if (w_pc !== 32'h8 || w_ill !== 8'd0) begin failures++; $display("FAIL wrap_end got=%h/%0d exp=00000008/0", w_pc, w_ill); end
  endtask

  task automatic test_reset_mid();
    bit to;
    for (int i = 0; i < 8; i++) load(8'(i), rand_word(1'b1));
    load(8'd8, SYSCALL);
    model(32'd0);
    ready = 1'b0;
    pulse_start();
    for (int c = 0; c < 4; c++) tick();
    rst = 1'b1; tick(); rst = 1'b0;
    checks++; if (valid !== 1'b0 || busy !== 1'b0) begin failures++; $display("FAIL rmid_state got=v%b/b%b exp=0/0", valid, busy); end
    checks++; if (pc !== 32'd0 || halted !== 1'b0) begin failures++; $display("FAIL rmid_pc got=%h/h%b exp=00000000/0", pc, halted); end
    pulse_start();
    run_prog(200, 1'b1, 1'b0, to);
    checks++; if (to) begin failures++; $display("FAIL rmid_halt_timeout got=busy exp=halted"); end
    checks++; if (got_q.size() != exp_q.size()) begin failures++; $display("FAIL rmid_len got=%0d exp=%0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      checks++; if (got_q[i] !== exp_q[i]) begin failures++; $display("FAIL rmid_word%0d got=%h exp=%h", i, got_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_ignore();
    bit to;
    for (int i = 0; i < 12; i++) load(8'(i), rand_word(1'b1));
    load(8'd12, SYSCALL);
    model(32'd0);
    for (int pass = 0; pass < 2; pass++) begin
      pulse_start();
      run_prog(300, pass == 0, pass == 0, to);
      checks++; if (to) begin failures++; $display("FAIL ign_halt_timeout pass=%0d got=busy exp=halted", pass); end
      checks++; if (got_q.size() != exp_q.size()) begin failures++; $display("FAIL ign_len pass=%0d got=%0d exp=%0d", pass, got_q.size(), exp_q.size()); end
      for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
        checks++; if (got_q[i] !== exp_q[i]) begin failures++; $display("FAIL ign_word%0d pass=%0d got=%h exp=%h", i, pass, got_q[i], exp_q[i]); end
      end
    end
  endtask

  task automatic test_random();
    bit to;
    int n;
    for (int it = 0; it < 6; it++) begin
      n = $urandom_range(1, 40);
      for (int i = 0; i < n; i++) load(8'(i), rand_word($urandom_range(0, 3) != 0));
      load(8'(n), SYSCALL);
      model(32'd0);
      pulse_start();
      run_prog(400, 1'b1, 1'b0, to);
      checks++; if (to) begin failures++; $display("FAIL rnd_halt_timeout it=%0d got=busy exp=halted", it); end
      checks++; if (got_q.size() != exp_q.size()) begin failures++; $display("FAIL rnd_len it=%0d got=%0d exp=%0d", it, got_q.size(), exp_q.size()); end
      for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
        checks++; if (got_q[i] !== exp_q[i]) begin failures++; $display("FAIL rnd_word%0d it=%0d got=%h exp=%h", i, it, got_q[i], exp_q[i]); end
      end
      checks++; if (ill !== 8'(exp_ill)) begin failures++; $display("FAIL rnd_ill it=%0d got=%0d exp=%0d", it, ill, exp_ill); end
      checks++; if (pc !== exp_pc) begin failures++; $display("FAIL rnd_pc it=%0d got=%h exp=%h", it, pc, exp_pc); end
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; load_en = 1'b0; load_addr = '0; load_data = '0; ready = 1'b0;
    w_start = 1'b0; w_load_en = 1'b0; w_load_addr = '0; w_load_data = '0; w_ready = 1'b0;
    for (int i = 0; i < 256; i++) mem_m[i] = '0;
    tick(); tick();
    rst = 1'b0;
    test_reset();
    test_basic();
    test_backpressure();
    test_illegal();
    test_wrap();
    test_reset_mid();
    test_ignore();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
